mp64_cluster_bus_arb: RTL

Round-robin arbiter sharing the single cluster memory bus among the N micro-cores of an `mp64_cluster`. It sits between the per-core bus ports and the cluster's external `bus_*` port. It grants one core at a time, registers that core's request onto the external bus, and routes `bus_ready`/`bus_rdata` back to the granted core. Optionally, a core can hold the bus across consecutive transactions for atomic read-modify-write sequences.

---
 rtl/mp64_cluster_bus_arb.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mp64_cluster_bus_arb.sv
// Round-robin arbiter for the mp64_cluster shared memory bus; registers the winner's request onto bus_*.
// Optional bus locking for atomic sequences is enabled with `define MP64_CLUSTER_ARB_LOCK_EN.
module mp64_cluster_bus_arb #(
    parameter int N = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_valid,
    input  logic [N*64-1:0] req_addr,
    input  logic [N*64-1:0] req_wdata,
    input  logic [N-1:0]    req_wen,
    input  logic [N*2-1:0]  req_size,
    input  logic [N-1:0]    req_lock,
    output logic [N-1:0]    req_ready,
    output logic [63:0]     req_rdata,
    output logic            bus_valid,
    output logic [63:0]     bus_addr,
    output logic [63:0]     bus_wdata,
    output logic            bus_wen,
    output logic [1:0]      bus_size,
    input  logic [63:0]     bus_rdata,
    input  logic            bus_ready,
    output logic [N-1:0]    arb_grant,
    output logic            bus_lock
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]    state;
    logic [IW-1:0] cur_idx;
    logic [IW-1:0] last_grant;
    logic [N-1:0]  eligible;
    logic [N-1:0]  cand;
    logic [IW-1:0] win_idx;

    // Lowest distance from last+1 (mod N) wins, so the last granted core ranks last.
    function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] c, input logic [IW-1:0] last);
        logic [IW-1:0] pick;
        int idx;
        pick = last;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(last) + k) % N;
            if (c[idx]) pick = IW'(idx);
        end
        return pick;
    endfunction

    function automatic logic [N-1:0] onehot(input logic [IW-1:0] i);
        logic [N-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

`ifdef MP64_CLUSTER_ARB_LOCK_EN
    logic lock_held;
    assign eligible = lock_held ? onehot(cur_idx) : '1;
    assign bus_lock = lock_held;
`else
    logic lock_unused;
    assign lock_unused = ^req_lock;
    assign eligible    = '1;
    assign bus_lock    = 1'b0;
`endif

    assign cand      = req_valid & eligible;
    assign win_idx   = rr_pick(cand, last_grant);
    assign req_ready = (state == BUSY && bus_ready) ? onehot(cur_idx) : '0;
    assign req_rdata = bus_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bus_valid  <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_wen    <= 1'b0;
            bus_size   <= '0;
            arb_grant  <= '0;
            cur_idx    <= '0;
            last_grant <= IW'(N - 1);
`ifdef MP64_CLUSTER_ARB_LOCK_EN
            lock_held  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|cand) begin
                        state     <= BUSY;
                        bus_valid <= 1'b1;
                        cur_idx   <= win_idx;
                        arb_grant <= onehot(win_idx);
                        bus_addr  <= req_addr[64*int'(win_idx) +: 64];
                        bus_wdata <= req_wdata[64*int'(win_idx) +: 64];
                        bus_wen   <= req_wen[win_idx];
                        bus_size  <= req_size[2*int'(win_idx) +: 2];
                    end
`ifdef MP64_CLUSTER_ARB_LOCK_EN
                    // An owner with a pending request keeps the lock through that transaction.
                    else if (lock_held && !req_lock[cur_idx]) begin
                        lock_held <= 1'b0;
                        arb_grant <= '0;
                    end
`endif
                end
                BUSY: begin
                    if (bus_ready) begin
                        state      <= IDLE;
                        bus_valid  <= 1'b0;
                        last_grant <= cur_idx;
`ifdef MP64_CLUSTER_ARB_LOCK_EN
                        if (req_lock[cur_idx]) begin
                            lock_held <= 1'b1;
                        end else begin
                            lock_held <= 1'b0;
                            arb_grant <= '0;
                        end
`else
                        arb_grant  <= '0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
